// File: rtl/gate_test_sequencer.sv
// Gate-test run sequencer: walks the loaded vectors, drives each input onto the
// DUT, waits for it to settle, captures and writes back the response, and
// tallies pass/fail. Owns the memory port while busy.
module gate_test_sequencer #(
  parameter logic [15:0] IN_BASE       = 16'h0008,
  parameter logic [15:0] EXP_BASE      = 16'h0010,
  parameter logic [15:0] OUT_BASE      = 16'h0018,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  OUT_MASK      = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  vec_count,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rd_data,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wr_data,
  output logic [7:0]  dut_in,
  input  logic [7:0]  dut_out,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pass_count,
  output logic [7:0]  fail_count,
  output logic [7:0]  first_fail_idx,
  output logic        any_fail
);

  typedef enum logic [3:0] {
    StIdle, StRdIn, StWaitIn, StRdExp, StWaitExp, StSettle, StCapture, StWrite, StDone
  } state_e;

  localparam logic [7:0] SettleInit = 8'(SETTLE_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  exp_q, exp_d;
  logic [7:0]  res_q, res_d;
  logic [7:0]  settle_q, settle_d;
  logic [7:0]  dut_in_q, dut_in_d;
  logic [7:0]  pass_q, pass_d;
  logic [7:0]  fail_q, fail_d;
  logic [7:0]  ffi_q, ffi_d;
  logic        any_fail_q, any_fail_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] addr_q, addr_d;

  // Next-state, datapath updates and registered-output decode.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    exp_d      = exp_q;
    res_d      = res_q;
    settle_d   = settle_q;
    dut_in_d   = dut_in_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    ffi_d      = ffi_q;
    any_fail_d = any_fail_q;
    addr_d     = addr_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pass_d     = 8'h00;
          fail_d     = 8'h00;
          any_fail_d = 1'b0;
          ffi_d      = 8'hFF;
          if (vec_count != 8'h00) begin
            count_d = vec_count;
            idx_d   = 8'h00;
            state_d = StRdIn;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRdIn:   state_d = StWaitIn;
      StWaitIn: begin
        dut_in_d = mem_rd_data;
        state_d  = StRdExp;
      end
      StRdExp:  state_d = StWaitExp;
      StWaitExp: begin
        exp_d    = mem_rd_data;
        settle_d = SettleInit;
        state_d  = StSettle;
      end
      StSettle: begin
        // Counts down to 1, so this state lasts exactly SETTLE_CYCLES cycles.
        settle_d = settle_q - 8'd1;
        if (settle_q <= 8'd1) state_d = StCapture;
      end
      StCapture: begin
        res_d = dut_out;
        if ((dut_out & OUT_MASK) == (exp_q & OUT_MASK)) begin
          pass_d = pass_q + 8'd1;
        end else begin
          fail_d     = fail_q + 8'd1;
          any_fail_d = 1'b1;
          if (ffi_q == 8'hFF) ffi_d = idx_q;
        end
        state_d = StWrite;
      end
      StWrite: begin
        if (idx_q == count_q - 8'd1) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = StRdIn;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Strobes and flags are decoded from the state being entered so that the
    // registered outputs line up with the state they belong to.
    busy_d  = (state_d != StIdle) && (state_d != StDone);
    done_d  = (state_d == StDone);
    rd_en_d = (state_d == StRdIn) || (state_d == StRdExp);
    wr_en_d = (state_d == StWrite);
    case (state_d)
      StRdIn:  addr_d = IN_BASE + {8'h00, idx_d};
      StRdExp: addr_d = EXP_BASE + {8'h00, idx_d};
      StWrite: addr_d = OUT_BASE + {8'h00, idx_d};
      default: addr_d = addr_q;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 8'h00;
      count_q    <= 8'h00;
      exp_q      <= 8'h00;
      res_q      <= 8'h00;
      settle_q   <= 8'h00;
      dut_in_q   <= 8'h00;
      pass_q     <= 8'h00;
      fail_q     <= 8'h00;
      ffi_q      <= 8'hFF;
      any_fail_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      exp_q      <= exp_d;
      res_q      <= res_d;
      settle_q   <= settle_d;
      dut_in_q   <= dut_in_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      ffi_q      <= ffi_d;
      any_fail_q <= any_fail_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
    end
  end

  assign mem_addr       = addr_q;
  assign mem_rd_en      = rd_en_q;
  assign mem_wr_en      = wr_en_q;
  assign mem_wr_data    = res_q;
  assign dut_in         = dut_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass_count     = pass_q;
  assign fail_count     = fail_q;
  assign first_fail_idx = ffi_q;
  assign any_fail       = any_fail_q;

endmodule

// File: doc/gate_test_sequencer.md
Name: gate_test_sequencer

Overview:
Sequences a full gate-test run after the host has loaded test vectors into shared memory. For each vector it reads the input byte and the expected byte from memory, drives the input onto the DUT, waits a settle time, samples the DUT output, writes it back to a result region, and tallies pass/fail. It sits between the UART receive path (start on rx_done) and the transmit path (done triggers result upload), and owns the memory port during a run.

Parameters:
IN_BASE, 16'h0008, base address of input vectors
EXP_BASE, 16'h0010, base address of expected outputs
OUT_BASE, 16'h0018, base address of captured results
SETTLE_CYCLES, 4, cycles dut_in is held before dut_out is sampled (legal range 1..255)
OUT_MASK, 8'hFF, bits of dut_out included in the compare

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle run request (driven from rx_done)
vec_count  input  8  number of vectors in the run, latched on accepted start
mem_addr  output  16  memory address
mem_rd_en  output  1  read strobe; data is valid on mem_rd_data the following cycle
mem_rd_data  input  8  memory read data
mem_wr_en  output  1  write strobe
mem_wr_data  output  8  memory write data
dut_in  output  8  registered logic inputs to the DUT
dut_out  input  8  DUT outputs
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at end of run (feeds tx start)
pass_count  output  8  vectors matching expected
fail_count  output  8  vectors mismatching expected
first_fail_idx  output  8  index of first mismatching vector, 8'hFF if none
any_fail  output  1  sticky: at least one mismatch this run

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; all outputs 0 except first_fail_idx=8'hFF; idx, latched count, expected register and settle counter cleared. Reset aborts a run in any state; no further mem strobes are issued.
- All outputs registered. mem_rd_en/mem_wr_en are never high in the same cycle and are low outside RD_*/WRITE.
- IDLE: on start=1 with vec_count!=0, latch count, idx=0, clear pass_count/fail_count/any_fail, set first_fail_idx=8'hFF, set busy=1, go to RD_IN. On start=1 with vec_count==0, clear the same counters and go directly to DONE with no memory access.
- start is ignored while busy=1.
- RD_IN: mem_rd_en=1, mem_addr=IN_BASE+idx; go to WAIT_IN.
- WAIT_IN: dut_in<=mem_rd_data; go to RD_EXP.
- RD_EXP: mem_rd_en=1, mem_addr=EXP_BASE+idx; go to WAIT_EXP.
- WAIT_EXP: exp<=mem_rd_data; settle counter<=SETTLE_CYCLES; go to SETTLE.
- SETTLE: decrement each cycle; leave when the counter reaches 1, so SETTLE occupies exactly SETTLE_CYCLES cycles. Go to CAPTURE.
- CAPTURE: res<=dut_out. If (dut_out & OUT_MASK)==(exp & OUT_MASK), pass_count++. Otherwise fail_count++ and any_fail<=1; first_fail_idx<=idx only if it is still 8'hFF. Go to WRITE.
- WRITE: mem_wr_en=1, mem_addr=OUT_BASE+idx, mem_wr_data=res (the unmasked raw output). If idx==count-1, go to DONE; else idx++ and go to RD_IN.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle; go to IDLE.
- Per-vector latency is 6+SETTLE_CYCLES cycles. Total run from start to done = 1 + count*(6+SETTLE_CYCLES) cycles.
- Address sums are 16-bit and wrap modulo 2^16. Counters are 8-bit; count max is 255, so they cannot overflow.
- dut_in, counters and first_fail_idx hold their values after DONE until the next accepted start or reset.

Test Plan:
1. rst held 2 cycles mid-SETTLE of vector 1 -> next cycle: busy=0, dut_in=0, first_fail_idx=FF, pass_count=0, no mem strobes afterwards, state IDLE.
2. Memory: in[8..9]={8'h03,8'h01}, exp[16..17]={8'h01,8'h00}, DUT=AND of bits0,1; start, vec_count=2, SETTLE=4 -> dut_in 03 then 01; writes 24<=01, 25<=00; pass=2, fail=0, any_fail=0, first_fail_idx=FF; done exactly 21 cycles after start.
3. Same stimulus, exp[17]=8'h01 -> fail_count=1, pass_count=1, first_fail_idx=1, any_fail=1, mem[25]=00.
4. OUT_MASK=8'h01, DUT drives 8'hF0|result, exp=8'h01 on result 1 -> counted as pass; written data 8'hF1.
5. start with vec_count=0 -> done pulses on the next cycle, no mem_rd_en/mem_wr_en, counters zero. Also: start re-pulsed while busy -> ignored, count unchanged.
6. IN_BASE=16'hFFFF, vec_count=2 -> reads at FFFF then 0000 (wrap); back-to-back runs restart with cleared counters.
